// File: rtl/qpsk_pkg.sv
// -----------------------------------------------------------------------------
// qpsk_pkg
// Shared constants and types for the QPSK modem framing blocks. The transmit
// framer (para2ser) and the receive deframer use the same word width and
// samples-per-bit values.
//
// Contents:
//   QPSK_WIDTH   bits per parallel word / serial frame (40)
//   QPSK_SAMPLE  clock cycles per serial bit (100, clock equals sample rate)
//   p2s_state_t  state encoding of the parallel-to-serial framer
//   cnt_width()  counter width needed to count 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package qpsk_pkg;

   localparam int QPSK_WIDTH  = 40;
   localparam int QPSK_SAMPLE = 100;

   typedef enum logic {
      P2S_IDLE = 1'b0,
      P2S_SEND = 1'b1
   } p2s_state_t;

   // Width of a counter that must hold the values 0..n-1.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
// Sample counter for sample-rate framing blocks. Counts 0..SAMPLE-1 while
// enabled and flags the last sample of every bit period.
//
// Ports:
//   clk   in   system clock (sample rate)
//   rst   in   asynchronous active-high reset
//   en    in   count enable
//   clr   in   synchronous clear (wins over en)
//   tick  out  high in the last sample cycle of a bit (count == SAMPLE-1)
// -----------------------------------------------------------------------------
module bit_tick_gen
   import qpsk_pkg::*;
#(
   parameter int SAMPLE = QPSK_SAMPLE
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = cnt_width(SAMPLE);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE - 1);

   logic [CW-1:0] sample_cnt_reg;
   logic          at_last;

   assign at_last = (sample_cnt_reg == LAST);

   // Terminal-value compare: the counter is reset to 0 explicitly rather than
   // relying on binary wrap, so any SAMPLE in 2..255 works.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt_reg <= '0;
      end else if (clr) begin
         sample_cnt_reg <= '0;
      end else if (en) begin
         sample_cnt_reg <= at_last ? '0 : sample_cnt_reg + 1'b1;
      end
   end

   assign tick = en && !clr && at_last;

endmodule

// File: rtl/para2ser.sv
// -----------------------------------------------------------------------------
// para2ser
// Parallel-to-serial framer for the QPSK modulator. Accepts WIDTH-bit words
// over valid/ready and shifts them out MSB first, each bit held for SAMPLE
// clock cycles. A one-word holding buffer lets the next word wait while a
// frame is in flight, so consecutive frames follow with no gap.
//
// Ports:
//   clk            in   system clock (sample rate)
//   rst            in   asynchronous active-high reset
//   para_i         in   parallel word, sampled only on accept
//   para_valid_i   in   para_i valid
//   para_ready_o   out  block can accept a word (combinational from state)
//   ser_o          out  serial bit, MSB first (registered)
//   bit_strobe_o   out  pulse in the first cycle of each bit (registered)
//   frame_start_o  out  pulse in the first cycle of each frame's MSB (registered)
//   busy_o         out  frame in progress (registered)
// -----------------------------------------------------------------------------
module para2ser
   import qpsk_pkg::*;
#(
   parameter int WIDTH  = QPSK_WIDTH,
   parameter int SAMPLE = QPSK_SAMPLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] para_i,
   input  logic             para_valid_i,
   output logic             para_ready_o,
   output logic             ser_o,
   output logic             bit_strobe_o,
   output logic             frame_start_o,
   output logic             busy_o
);

   localparam int            BW       = cnt_width(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   p2s_state_t       state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             hold_full_reg, hold_full_next;
   logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;

   logic ser_reg, ser_next;
   logic strobe_reg, strobe_next;
   logic fstart_reg, fstart_next;
   logic busy_reg, busy_next;

   logic accept;
   logic tick;
   logic frame_end;
   logic new_frame;
   logic new_bit;
   logic cnt_en;
   logic cnt_clr;

   assign para_ready_o = !hold_full_reg && !rst;
   assign accept       = para_valid_i && para_ready_o;

   // The sample counter is held at 0 in IDLE, so the first bit of a frame
   // started from IDLE always gets a full SAMPLE cycles.
   assign cnt_en  = (state_reg == P2S_SEND);
   assign cnt_clr = (state_reg == P2S_IDLE);

   bit_tick_gen #(
      .SAMPLE (SAMPLE)
   ) u_bit_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (cnt_en),
      .clr  (cnt_clr),
      .tick (tick)
   );

   assign frame_end = tick && (bit_cnt_reg == LAST_BIT);

   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      bit_cnt_next   = bit_cnt_reg;
      new_frame      = 1'b0;
      new_bit        = 1'b0;

      case (state_reg)
         P2S_IDLE: begin
            if (accept) begin
               shift_next   = para_i;
               bit_cnt_next = '0;
               state_next   = P2S_SEND;
               new_frame    = 1'b1;
            end
         end

         P2S_SEND: begin
            if (frame_end) begin
               bit_cnt_next = '0;
               if (hold_full_reg) begin
                  shift_next     = hold_reg;
                  hold_full_next = 1'b0;
                  new_frame      = 1'b1;
               end else if (accept) begin
                  // Word arrives exactly at the frame boundary with the
                  // buffer empty: bypass the hold register, no gap.
                  shift_next = para_i;
                  new_frame  = 1'b1;
               end else begin
                  state_next = P2S_IDLE;
               end
            end else begin
               if (tick) begin
                  shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  new_bit      = 1'b1;
               end
               if (accept) begin
                  hold_next      = para_i;
                  hold_full_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = P2S_IDLE;
         end
      endcase

      // Outputs are registered from the next-state values so they line up
      // with the shift register contents in the same cycle.
      ser_next    = (state_next == P2S_SEND) && shift_next[WIDTH-1];
      busy_next   = (state_next == P2S_SEND);
      strobe_next = new_frame || new_bit;
      fstart_next = new_frame;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= P2S_IDLE;
         shift_reg     <= '0;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         bit_cnt_reg   <= '0;
         ser_reg       <= 1'b0;
         strobe_reg    <= 1'b0;
         fstart_reg    <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         hold_reg      <= hold_next;
         hold_full_reg <= hold_full_next;
         bit_cnt_reg   <= bit_cnt_next;
         ser_reg       <= ser_next;
         strobe_reg    <= strobe_next;
         fstart_reg    <= fstart_next;
         busy_reg      <= busy_next;
      end
   end

   assign ser_o         = ser_reg;
   assign bit_strobe_o  = strobe_reg;
   assign frame_start_o = fstart_reg;
   assign busy_o        = busy_reg;

endmodule

// File: tb/tb_para2ser.sv
// -----------------------------------------------------------------------------
// tb_para2ser
// Self-checking bench for para2ser. Instance A runs at SAMPLE=4 against a
// cycle-timeline reference model; instance B runs at SAMPLE=100 and is looped
// back through a behavioural 40-bit serial-to-parallel receiver.
// -----------------------------------------------------------------------------
module tb_para2ser;
   import qpsk_pkg::*;

   localparam int W  = QPSK_WIDTH;
   localparam int SA = 4;
   localparam int SB = QPSK_SAMPLE;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] pa_data = '0;
   logic [W-1:0] pb_data = '0;
   logic         pa_valid = 1'b0;
   logic         pb_valid = 1'b0;
   logic         a_ready, a_ser, a_strobe, a_fs, a_busy;
   logic         b_ready, b_ser, b_strobe, b_fs, b_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   para2ser #(.WIDTH(W), .SAMPLE(SA)) dut_a (
      .clk(clk), .rst(rst), .para_i(pa_data), .para_valid_i(pa_valid),
      .para_ready_o(a_ready), .ser_o(a_ser), .bit_strobe_o(a_strobe),
      .frame_start_o(a_fs), .busy_o(a_busy)
   );

   para2ser #(.WIDTH(W), .SAMPLE(SB)) dut_b (
      .clk(clk), .rst(rst), .para_i(pb_data), .para_valid_i(pb_valid),
      .para_ready_o(b_ready), .ser_o(b_ser), .bit_strobe_o(b_strobe),
      .frame_start_o(b_fs), .busy_o(b_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
   endtask

   // ---------------------------------------------------------------------
   // Reference model for instance A: a frame is a word plus the cycle its
   // MSB first appears; everything else is derived arithmetically.
   // ---------------------------------------------------------------------
   int           tcyc = 0;
   bit           m_have = 0, m_pend = 0, m_acc = 0;
   logic [W-1:0] m_word = '0, m_pw = '0;
   int           m_fstart = 0;

   initial forever begin
      @(posedge clk);
      tcyc++;
      m_acc = 0;
      if (rst) begin
         m_have = 0;
         m_pend = 0;
      end else begin
         m_acc = pa_valid && !m_pend;
         if (m_have && (tcyc - m_fstart == W * SA)) begin
            if (m_pend) begin
               m_word = m_pw; m_fstart = tcyc; m_pend = 0;
            end else if (m_acc) begin
               m_word = pa_data; m_fstart = tcyc;
            end else begin
               m_have = 0;
            end
         end else if (!m_have) begin
            if (m_acc) begin
               m_have = 1; m_word = pa_data; m_fstart = tcyc;
            end
         end else if (m_acc) begin
            m_pend = 1; m_pw = pa_data;
         end
      end
   end

   // Per-cycle comparison of {ser, strobe, frame_start, busy, ready}.
   initial forever begin
      logic [4:0] exp;
      int off;
      @(negedge clk);
      exp = 5'b0;
      if (!rst) begin
         if (m_have) begin
            off = tcyc - m_fstart;
            exp[4] = m_word[W - 1 - off / SA];
            exp[3] = (off % SA == 0);
            exp[2] = (off == 0);
            exp[1] = 1'b1;
         end
         exp[0] = !m_pend;
      end
      check("a_cycle{ser,strb,fs,busy,rdy}", {a_ser, a_strobe, a_fs, a_busy, a_ready}, exp);
   end

   // ---------------------------------------------------------------------
   // Behavioural 40-bit receiver for instance B: aligns on frame_start and
   // samples ser_o in the middle of each bit.
   // ---------------------------------------------------------------------
   logic [W-1:0] rx_q[$];
   logic [W-1:0] tx_q[$];

   initial begin
      bit           act;
      int           cnt, nb;
      logic [W-1:0] sh;
      act = 0; cnt = 0; nb = 0; sh = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            act = 0;
         end else begin
            if (b_fs) begin
               act = 1; cnt = 0; nb = 0;
            end
            if (act) begin
               if (cnt % SB == SB / 2) begin
                  sh = {sh[W-2:0], b_ser};
                  nb++;
                  if (nb == W) begin
                     rx_q.push_back(sh);
                     act = 0;
                  end
               end
               cnt++;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers for instance A
   // ---------------------------------------------------------------------
   task automatic send_word_a(input logic [W-1:0] w, input int bound, output int t_acc);
      bit ok;
      ok = 0;
      pa_data  = w;
      pa_valid = 1'b1;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk); #1;
         if (m_acc) begin
            ok = 1;
            break;
         end
      end
      pa_valid = 1'b0;
      t_acc = tcyc;
      if (!ok) fail_timeout("send_word_a");
   endtask

   task automatic wait_until_cycle(input int c);
      while (tcyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle_a();
      bit ok;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!a_busy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_timeout("wait_idle_a");
   endtask

   // Returns the offset (from t0) of the first frame_start pulse seen.
   task automatic find_fs(input int t0, output int rel);
      rel = -1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (a_fs) begin
            rel = tcyc - t0;
            break;
         end
      end
      if (rel < 0) fail_timeout("find_fs");
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [63:0] r64;
      r64 = {$urandom, $urandom};
      return r64[W-1:0];
   endfunction

   typedef struct {
      int d;        // edge offset (from first accept) at which word 2 is offered
      int exp_rel;  // cycle offset at which word 2's frame must start
   } pair_vec_t;

   pair_vec_t pv[6];

   initial begin
      int t0, ta, rel;
      int busy_n, strobe_n, fs_n, ser_n;
      logic [W-1:0] w, rx;

      pv[0] = '{d: 2,   exp_rel: 160};
      pv[1] = '{d: 80,  exp_rel: 160};
      pv[2] = '{d: 159, exp_rel: 160};
      pv[3] = '{d: 160, exp_rel: 160};  // frame-end bypass
      pv[4] = '{d: 161, exp_rel: 161};  // one cycle late: idle first
      pv[5] = '{d: 175, exp_rel: 175};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_b_outputs", {b_ser, b_strobe, b_fs, b_busy, b_ready}, 5'b0);
      #2 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", a_ready, 1'b1);

      // Single word, SAMPLE=4
      w = 40'hA5_0F_C3_96_3C;
      send_word_a(w, 5, t0);
      busy_n = 0; strobe_n = 0; fs_n = 0; rx = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         busy_n   += int'(a_busy);
         strobe_n += int'(a_strobe);
         fs_n     += int'(a_fs);
         if ((tcyc - t0) < W * SA && (tcyc - t0) % SA == 2) rx = {rx[W-2:0], a_ser};
      end
      check("single_busy_cycles", busy_n, 160);
      check("single_bit_strobes", strobe_n, 40);
      check("single_frame_starts", fs_n, 1);
      check("single_word_bits", rx, w);

      // Table: second word offered at various offsets
      foreach (pv[k]) begin
         send_word_a(rand_word(), 5, t0);
         wait_until_cycle(t0 + pv[k].d - 1);
         send_word_a(rand_word(), 5, ta);
         check("pair_accept_edge", ta - t0, pv[k].d);
         find_fs(t0, rel);
         check("pair_frame2_start", rel, pv[k].exp_rel);
         wait_idle_a();
      end

      // Third word offered while the hold buffer is full
      send_word_a(rand_word(), 5, t0);
      wait_until_cycle(t0 + 9);
      send_word_a(rand_word(), 5, ta);
      wait_until_cycle(t0 + 19);
      pa_data  = rand_word();
      pa_valid = 1'b1;
      @(negedge clk);
      check("hold_full_ready", a_ready, 1'b0);
      send_word_a(pa_data, 400, ta);
      check("hold_full_accept_edge", ta - t0, 161);
      find_fs(t0, rel);
      check("hold_full_frame3_start", rel, 320);
      wait_idle_a();

      // Reset mid-frame (bit 17) with hold full
      send_word_a(rand_word(), 5, t0);
      wait_until_cycle(t0 + 4);
      send_word_a(rand_word(), 5, ta);
      wait_until_cycle(t0 + 17 * SA + 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("rst_midframe_outputs", {a_ser, a_strobe, a_fs, a_busy, a_ready}, 5'b0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1 check("rst_release_ready_busy", {a_ready, a_busy}, 2'b10);
      busy_n = 0; fs_n = 0; ser_n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         busy_n += int'(a_busy);
         fs_n   += int'(a_fs);
         ser_n  += int'(a_ser);
      end
      check("rst_held_word_dropped", {busy_n[15:0], fs_n[15:0], ser_n[15:0]}, 48'h0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (m_acc) pa_valid = 1'b0;
         if (!pa_valid && $urandom_range(0, 99) < 3) begin
            pa_data  = rand_word();
            pa_valid = 1'b1;
         end
      end
      pa_valid = 1'b0;
      wait_idle_a();

      // Loopback at SAMPLE=100 through the receiver
      for (int k = 0; k < 5; k++) begin
         bit ok;
         int gap;
         gap = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 300));
         repeat (gap) @(posedge clk);
         #1;
         pb_data  = rand_word();
         pb_valid = 1'b1;
         ok = 0;
         for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            if (b_ready) begin
               tx_q.push_back(pb_data);
               ok = 1;
               break;
            end
         end
         @(posedge clk); #1;
         pb_valid = 1'b0;
         if (!ok) fail_timeout("loopback_send");
      end
      begin
         bit ok;
         ok = 0;
         for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            if (rx_q.size() >= tx_q.size() && !b_busy) begin
               ok = 1;
               break;
            end
         end
         if (!ok) fail_timeout("loopback_receive");
      end
      check("loopback_word_count", rx_q.size(), tx_q.size());
      while (tx_q.size() > 0 && rx_q.size() > 0) begin
         check("loopback_word", rx_q.pop_front(), tx_q.pop_front());
      end
      check("loopback_idle_strobe", {b_busy, b_strobe}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
